// File: rtl/execute_stage_if.sv
// Execute-stage bus: EX-side operands/control from decode and the registered
// *_mem results toward the memory stage. Decode holds the master modport.
interface execute_stage_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] reg_s_data_ex;
   logic [DATA_WIDTH-1:0] reg_t_data_ex;
   logic [DATA_WIDTH-1:0] imm_data_ex;
   logic                  alu_src_sel_ex;
   logic [3:0]            alu_op_ex;
   logic [2:0]            md_op_ex;
   logic                  reg_d_we_ex;
   logic [4:0]            reg_d_addr_ex;
   logic                  reg_d_data_sel_ex;
   logic [3:0]            mem_we_ex;
   logic                  stall_ex;
   logic [DATA_WIDTH-1:0] alu_data_mem;
   logic [DATA_WIDTH-1:0] reg_t_data_mem;
   logic                  reg_d_we_mem;
   logic [4:0]            reg_d_addr_mem;
   logic                  reg_d_data_sel_mem;
   logic [3:0]            mem_we_mem;

   modport master (
      output reg_s_data_ex, reg_t_data_ex, imm_data_ex, alu_src_sel_ex, alu_op_ex,
             md_op_ex, reg_d_we_ex, reg_d_addr_ex, reg_d_data_sel_ex, mem_we_ex,
      input  stall_ex, alu_data_mem, reg_t_data_mem, reg_d_we_mem, reg_d_addr_mem,
             reg_d_data_sel_mem, mem_we_mem
   );

   modport slave (
      input  reg_s_data_ex, reg_t_data_ex, imm_data_ex, alu_src_sel_ex, alu_op_ex,
             md_op_ex, reg_d_we_ex, reg_d_addr_ex, reg_d_data_sel_ex, mem_we_ex,
      output stall_ex, alu_data_mem, reg_t_data_mem, reg_d_we_mem, reg_d_addr_mem,
             reg_d_data_sel_mem, mem_we_mem
   );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage: single-cycle ALU, EX/MEM pipeline register and, when
// EXECUTE_MULDIV_EN is defined, an iterative 32-cycle mul/div unit with HI/LO
// and a stall toward decode. Without the macro MFHI/MFLO read 0 and no stall.
module execute_stage #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic            clk,
   input logic            rst,
   execute_stage_if.slave ex_if
);
   localparam logic [3:0] AluAdd  = 4'd0;
   localparam logic [3:0] AluSub  = 4'd1;
   localparam logic [3:0] AluAnd  = 4'd2;
   localparam logic [3:0] AluOr   = 4'd3;
   localparam logic [3:0] AluXor  = 4'd4;
   localparam logic [3:0] AluNor  = 4'd5;
   localparam logic [3:0] AluSlt  = 4'd6;
   localparam logic [3:0] AluSltu = 4'd7;
   localparam logic [3:0] AluSll  = 4'd8;
   localparam logic [3:0] AluSrl  = 4'd9;
   localparam logic [3:0] AluSra  = 4'd10;
   localparam logic [3:0] AluLui  = 4'd11;

   localparam logic [2:0] MdMult  = 3'd1;
   localparam logic [2:0] MdDiv   = 3'd3;
   localparam logic [2:0] MdMfhi  = 3'd5;
   localparam logic [2:0] MdMflo  = 3'd6;

   logic [DATA_WIDTH-1:0] op_a, op_b, alu_res, res_data;
   logic [DATA_WIDTH-1:0] hi_rd, lo_rd;
   logic                  stall;

   logic [DATA_WIDTH-1:0] alu_data_q, alu_data_d;
   logic [DATA_WIDTH-1:0] reg_t_data_q, reg_t_data_d;
   logic                  reg_d_we_q, reg_d_we_d;
   logic [4:0]            reg_d_addr_q, reg_d_addr_d;
   logic                  reg_d_data_sel_q, reg_d_data_sel_d;
   logic [3:0]            mem_we_q, mem_we_d;

   assign op_a = ex_if.reg_s_data_ex;
   assign op_b = ex_if.alu_src_sel_ex ? ex_if.imm_data_ex : ex_if.reg_t_data_ex;

   // ALU result; codes 12-15 yield 0
   always_comb begin
      alu_res = '0;
      case (ex_if.alu_op_ex)
         AluAdd:  alu_res = op_a + op_b;
         AluSub:  alu_res = op_a - op_b;
         AluAnd:  alu_res = op_a & op_b;
         AluOr:   alu_res = op_a | op_b;
         AluXor:  alu_res = op_a ^ op_b;
         AluNor:  alu_res = ~(op_a | op_b);
         AluSlt:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         AluSltu: alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
         AluSll:  alu_res = op_b << op_a[4:0];
         AluSrl:  alu_res = op_b >> op_a[4:0];
         AluSra:  alu_res = unsigned'($signed(op_b) >>> op_a[4:0]);
         AluLui:  alu_res = op_b << 16;
         default: alu_res = '0;
      endcase
   end

`ifdef EXECUTE_MULDIV_EN
   logic        busy_q, busy_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;          // product or quotient gets negated
   logic        rem_neg_q, rem_neg_d;  // remainder follows dividend sign
   logic        div_zero_q, div_zero_d;
   logic [31:0] dividend_q, dividend_d;
   logic [31:0] mcand_q, mcand_d;      // multiplicand or divisor magnitude
   logic [31:0] acc_hi_q, acc_hi_d;
   logic [31:0] acc_lo_q, acc_lo_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic        md_op_sel, md_rd_sel, md_start, md_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, step_hi, step_lo;
   logic [32:0] mul_sum, rem_sh;
   logic [63:0] prod;

   assign md_op_sel = (ex_if.md_op_ex >= 3'd1) && (ex_if.md_op_ex <= 3'd4);
   assign md_rd_sel = (ex_if.md_op_ex == MdMfhi) || (ex_if.md_op_ex == MdMflo);
   assign stall     = busy_q && (md_op_sel || md_rd_sel);
   assign md_start  = md_op_sel && !busy_q;
   assign md_signed = (ex_if.md_op_ex == MdMult) || (ex_if.md_op_ex == MdDiv);
   assign a_neg     = md_signed && ex_if.reg_s_data_ex[31];
   assign b_neg     = md_signed && ex_if.reg_t_data_ex[31];
   assign a_mag     = a_neg ? -ex_if.reg_s_data_ex : ex_if.reg_s_data_ex;
   assign b_mag     = b_neg ? -ex_if.reg_t_data_ex : ex_if.reg_t_data_ex;
   assign hi_rd     = hi_q;
   assign lo_rd     = lo_q;

   // One radix-2 step per busy cycle on unsigned magnitudes; signs fixed at the end
   always_comb begin
      busy_d     = busy_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      div_zero_d = div_zero_q;
      dividend_d = dividend_q;
      mcand_d    = mcand_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      // shift-add multiply: {acc_hi, acc_lo} holds partial product and multiplier
      mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
      // restoring divide: acc_hi is the remainder, acc_lo shifts dividend out, quotient in
      rem_sh     = {acc_hi_q, acc_lo_q[31]};
      if (is_div_q) begin
         if (rem_sh >= {1'b0, mcand_q}) begin
            step_hi = rem_sh[31:0] - mcand_q;
            step_lo = {acc_lo_q[30:0], 1'b1};
         end else begin
            step_hi = rem_sh[31:0];
            step_lo = {acc_lo_q[30:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[32:1];
         step_lo = {mul_sum[0], acc_lo_q[31:1]};
      end
      prod = {step_hi, step_lo};
      if (busy_q) begin
         acc_hi_d = step_hi;
         acc_lo_d = step_lo;
         cnt_d    = cnt_q - 6'd1;
         if (cnt_q == 6'd1) begin
            busy_d = 1'b0;
            if (!is_div_q) begin
               {hi_d, lo_d} = neg_q ? -prod : prod;
            end else if (div_zero_q) begin
               lo_d = 32'hFFFF_FFFF;
               hi_d = dividend_q;
            end else begin
               lo_d = neg_q ? -step_lo : step_lo;
               hi_d = rem_neg_q ? -step_hi : step_hi;
            end
         end
      end else if (md_start) begin
         busy_d     = 1'b1;
         cnt_d      = 6'd32;
         is_div_d   = ex_if.md_op_ex >= MdDiv;
         neg_d      = a_neg ^ b_neg;
         rem_neg_d  = a_neg;
         div_zero_d = ex_if.reg_t_data_ex == 32'd0;
         dividend_d = ex_if.reg_s_data_ex;
         mcand_d    = b_mag;
         acc_hi_d   = 32'd0;
         acc_lo_d   = a_mag;
      end
   end

   // Mul/div state; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= 1'b0;
         cnt_q      <= 6'd0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         dividend_q <= 32'd0;
         mcand_q    <= 32'd0;
         acc_hi_q   <= 32'd0;
         acc_lo_q   <= 32'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
      end else begin
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         div_zero_q <= div_zero_d;
         dividend_q <= dividend_d;
         mcand_q    <= mcand_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end
`else
   assign stall = 1'b0;
   assign hi_rd = '0;
   assign lo_rd = '0;
`endif

   assign ex_if.stall_ex = stall;

   // EX/MEM next state: stalled cycles inject an all-zero bubble
   always_comb begin
      res_data         = alu_res;
      alu_data_d       = '0;
      reg_t_data_d     = '0;
      reg_d_we_d       = 1'b0;
      reg_d_addr_d     = 5'd0;
      reg_d_data_sel_d = 1'b0;
      mem_we_d         = 4'd0;
      if (ex_if.md_op_ex == MdMfhi) begin
         res_data = hi_rd;
      end else if (ex_if.md_op_ex == MdMflo) begin
         res_data = lo_rd;
      end
      if (!stall) begin
         alu_data_d       = res_data;
         reg_t_data_d     = ex_if.reg_t_data_ex;
         reg_d_we_d       = ex_if.reg_d_we_ex;
         reg_d_addr_d     = ex_if.reg_d_addr_ex;
         reg_d_data_sel_d = ex_if.reg_d_data_sel_ex;
         mem_we_d         = ex_if.mem_we_ex;
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_data_q       <= '0;
         reg_t_data_q     <= '0;
         reg_d_we_q       <= 1'b0;
         reg_d_addr_q     <= 5'd0;
         reg_d_data_sel_q <= 1'b0;
         mem_we_q         <= 4'd0;
      end else begin
         alu_data_q       <= alu_data_d;
         reg_t_data_q     <= reg_t_data_d;
         reg_d_we_q       <= reg_d_we_d;
         reg_d_addr_q     <= reg_d_addr_d;
         reg_d_data_sel_q <= reg_d_data_sel_d;
         mem_we_q         <= mem_we_d;
      end
   end

   assign ex_if.alu_data_mem       = alu_data_q;
   assign ex_if.reg_t_data_mem     = reg_t_data_q;
   assign ex_if.reg_d_we_mem       = reg_d_we_q;
   assign ex_if.reg_d_addr_mem     = reg_d_addr_q;
   assign ex_if.reg_d_data_sel_mem = reg_d_data_sel_q;
   assign ex_if.mem_we_mem         = mem_we_q;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: table-driven ALU vectors plus hand
// sequences for mul/div stalls and reset abort. Mul/div expectations follow
// EXECUTE_MULDIV_EN the same way the design does.
module tb_execute_stage;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   execute_stage_if #(.DATA_WIDTH(32)) ex_if ();

   execute_stage #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .ex_if (ex_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        sel;
      logic [31:0] a;
      logic [31:0] t;
      logic [31:0] imm;
      logic        we;
      logic [4:0]  addr;
      logic        dsel;
      logic [3:0]  mwe;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic sel, input logic [31:0] a,
                        input logic [31:0] t, input logic [31:0] imm, input logic [2:0] md,
                        input logic we, input logic [4:0] addr, input logic dsel,
                        input logic [3:0] mwe);
      ex_if.alu_op_ex         = op;
      ex_if.alu_src_sel_ex    = sel;
      ex_if.reg_s_data_ex     = a;
      ex_if.reg_t_data_ex     = t;
      ex_if.imm_data_ex       = imm;
      ex_if.md_op_ex          = md;
      ex_if.reg_d_we_ex       = we;
      ex_if.reg_d_addr_ex     = addr;
      ex_if.reg_d_data_sel_ex = dsel;
      ex_if.mem_we_ex         = mwe;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step while stalled (bounded), checking each stalled edge produced a bubble
   task automatic wait_stall(input string name, output int n);
      n = 0;
      while (ex_if.stall_ex && n < 64) begin
         step();
         n++;
         chk({name, " bubble we"}, {31'd0, ex_if.reg_d_we_mem}, 32'd0);
         chk({name, " bubble mem_we"}, {28'd0, ex_if.mem_we_mem}, 32'd0);
      end
   endtask

   task automatic md_issue(input string name, input logic [2:0] md, input logic [31:0] a,
                           input logic [31:0] t, input int exp_stalls);
      int n;
      drive(4'd0, 1'b0, a, t, 32'd0, md, 1'b0, 5'd0, 1'b0, 4'd0);
      wait_stall(name, n);
      chk({name, " stalls"}, n, exp_stalls);
      step();
   endtask

   task automatic md_read(input string name, input logic [2:0] md, input logic [31:0] exp,
                          input int exp_stalls);
      int n;
      drive(4'd0, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'd0, md, 1'b1, 5'd9, 1'b0, 4'd0);
      wait_stall(name, n);
      chk({name, " stalls"}, n, exp_stalls);
      step();
      chk({name, " data"}, ex_if.alu_data_mem, exp);
      chk({name, " we"}, {31'd0, ex_if.reg_d_we_mem}, 32'd1);
      chk({name, " addr"}, {27'd0, ex_if.reg_d_addr_mem}, 32'd9);
   endtask

   task automatic chk_zero(input string name);
      chk({name, " alu"}, ex_if.alu_data_mem, 32'd0);
      chk({name, " rt"}, ex_if.reg_t_data_mem, 32'd0);
      chk({name, " ctl"}, {21'd0, ex_if.reg_d_we_mem, ex_if.reg_d_addr_mem,
                           ex_if.reg_d_data_sel_mem, ex_if.mem_we_mem}, 32'd0);
   endtask

   initial begin
      //           op     sel   a             t             imm           we    addr   dsel  mwe    exp
      vecs[0]  = '{4'd0,  1'b1, 32'h7FFFFFFF, 32'h0000AAAA, 32'h00000001, 1'b1, 5'd3,  1'b0, 4'h0, 32'h80000000};
      vecs[1]  = '{4'd6,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b1, 5'd4,  1'b0, 4'h0, 32'h00000001};
      vecs[2]  = '{4'd7,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b1, 5'd5,  1'b0, 4'h0, 32'h00000000};
      vecs[3]  = '{4'd10, 1'b0, 32'h00000004, 32'h80000000, 32'h0,        1'b1, 5'd6,  1'b0, 4'h0, 32'hF8000000};
      vecs[4]  = '{4'd1,  1'b0, 32'h00000000, 32'h00000001, 32'h0,        1'b1, 5'd7,  1'b0, 4'h0, 32'hFFFFFFFF};
      vecs[5]  = '{4'd2,  1'b1, 32'hF0F0F0F0, 32'h0,        32'h0FF00FF0, 1'b1, 5'd8,  1'b0, 4'h0, 32'h00F000F0};
      vecs[6]  = '{4'd3,  1'b1, 32'hF0F0F0F0, 32'h0,        32'h0FF00FF0, 1'b1, 5'd9,  1'b0, 4'h0, 32'hFFF0FFF0};
      vecs[7]  = '{4'd4,  1'b1, 32'hF0F0F0F0, 32'h0,        32'h0FF00FF0, 1'b1, 5'd10, 1'b0, 4'h0, 32'hFF00FF00};
      vecs[8]  = '{4'd5,  1'b1, 32'hF0F0F0F0, 32'h0,        32'h0FF00FF0, 1'b1, 5'd11, 1'b0, 4'h0, 32'h000F000F};
      vecs[9]  = '{4'd8,  1'b0, 32'h0000001F, 32'h00000001, 32'h0,        1'b1, 5'd12, 1'b0, 4'h0, 32'h80000000};
      vecs[10] = '{4'd9,  1'b0, 32'h00000024, 32'h80000000, 32'h0,        1'b1, 5'd13, 1'b0, 4'h0, 32'h08000000};
      vecs[11] = '{4'd11, 1'b1, 32'h0,        32'h0,        32'h00001234, 1'b1, 5'd14, 1'b0, 4'h0, 32'h12340000};
      vecs[12] = '{4'd12, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b1, 5'd15, 1'b0, 4'h0, 32'h00000000};
      vecs[13] = '{4'd15, 1'b1, 32'h12345678, 32'h0,        32'h0000FFFF, 1'b0, 5'd16, 1'b0, 4'h0, 32'h00000000};
      vecs[14] = '{4'd0,  1'b1, 32'h00001000, 32'hDEADBEEF, 32'h00000008, 1'b0, 5'd0,  1'b1, 4'hF, 32'h00001008};

      // Reset dominates a live instruction
      rst = 1'b1;
      drive(4'd0, 1'b0, 32'd1, 32'd1, 32'd0, 3'd0, 1'b1, 5'd2, 1'b1, 4'hF);
      step();
      step();
      chk_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].t, vecs[i].imm, 3'd0, vecs[i].we,
               vecs[i].addr, vecs[i].dsel, vecs[i].mwe);
         chk($sformatf("vec%0d stall", i), {31'd0, ex_if.stall_ex}, 32'd0);
         step();
         chk($sformatf("vec%0d alu", i), ex_if.alu_data_mem, vecs[i].exp);
         chk($sformatf("vec%0d rt", i), ex_if.reg_t_data_mem, vecs[i].t);
         chk($sformatf("vec%0d ctl", i),
             {21'd0, ex_if.reg_d_we_mem, ex_if.reg_d_addr_mem, ex_if.reg_d_data_sel_mem,
              ex_if.mem_we_mem},
             {21'd0, vecs[i].we, vecs[i].addr, vecs[i].dsel, vecs[i].mwe});
      end

`ifdef EXECUTE_MULDIV_EN
      // MULT then back-to-back MFLO/MFHI
      md_issue("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 0);
      md_read("mult mflo", 3'd6, 32'hFFFFFFFA, 32);
      md_read("mult mfhi", 3'd5, 32'hFFFFFFFF, 0);

      md_issue("div", 3'd3, 32'hFFFFFFF9, 32'd2, 0);
      md_read("div mflo", 3'd6, 32'hFFFFFFFD, 32);
      md_read("div mfhi", 3'd5, 32'hFFFFFFFF, 0);

      md_issue("divu0", 3'd4, 32'd7, 32'd0, 0);
      md_read("divu0 mflo", 3'd6, 32'hFFFFFFFF, 32);
      md_read("divu0 mfhi", 3'd5, 32'h00000007, 0);

      md_issue("divmin", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
      md_read("divmin mflo", 3'd6, 32'h80000000, 32);
      md_read("divmin mfhi", 3'd5, 32'h00000000, 0);

      // Independent ADDs flow while MULTU runs in the background
      md_issue("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      for (int i = 0; i < 3; i++) begin
         drive(4'd0, 1'b0, 32'd100 + i, 32'd5, 32'd0, 3'd0, 1'b1, 5'd20 + 5'(i), 1'b0, 4'h0);
         chk($sformatf("bg add%0d stall", i), {31'd0, ex_if.stall_ex}, 32'd0);
         step();
         chk($sformatf("bg add%0d alu", i), ex_if.alu_data_mem, 32'd105 + i);
         chk($sformatf("bg add%0d we", i), {31'd0, ex_if.reg_d_we_mem}, 32'd1);
      end
      md_read("multu mfhi", 3'd5, 32'hFFFFFFFE, 29);
      md_read("multu mflo", 3'd6, 32'h00000001, 0);

      // A new op held while busy is accepted once, on the first non-busy edge
      md_issue("div2", 3'd3, 32'hFFFFFFF9, 32'd2, 0);
      md_issue("held mult", 3'd1, 32'hFFFFFFFE, 32'd3, 32);
      md_read("held mflo", 3'd6, 32'hFFFFFFFA, 32);
      md_read("held mfhi", 3'd5, 32'hFFFFFFFF, 0);
`else
      // No mul/div hardware: ops pass through, never stall, reads return 0
      drive(4'd0, 1'b0, 32'hFFFFFFFE, 32'd3, 32'd0, 3'd1, 1'b0, 5'd0, 1'b0, 4'h0);
      chk("nomd mult stall", {31'd0, ex_if.stall_ex}, 32'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(4'd0, 1'b0, 32'h5, 32'h6, 32'd0, 3'd6, 1'b1, 5'd9, 1'b0, 4'h0);
         chk($sformatf("nomd mflo%0d stall", i), {31'd0, ex_if.stall_ex}, 32'd0);
         step();
         chk($sformatf("nomd mflo%0d data", i), ex_if.alu_data_mem, 32'd0);
         chk($sformatf("nomd mflo%0d we", i), {31'd0, ex_if.reg_d_we_mem}, 32'd1);
      end
`endif

      // Reset on busy cycle 10 of a DIVU aborts it
      md_issue("rst divu", 3'd4, 32'd100, 32'd7, 0);
      for (int i = 0; i < 9; i++) begin
         drive(4'd0, 1'b0, 32'd1, 32'd2, 32'd0, 3'd0, 1'b1, 5'd3, 1'b1, 4'h3);
         step();
      end
      chk("pre-rst alu", ex_if.alu_data_mem, 32'd3);
      rst = 1'b1;
      step();
      chk_zero("mid-div reset");
      rst = 1'b0;
      md_read("post-rst mfhi", 3'd5, 32'd0, 0);
      md_read("post-rst mflo", 3'd6, 32'd0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the bench always reaches its summary
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) pipeline stage of the 5-stage MIPS core.
- Sits between decode and the memory stage, and registers its results into the memory stage's `*_mem` inputs.
- Contains a single-cycle ALU and an iterative 32-cycle multiply/divide unit with HI/LO registers.
- Raises a stall toward decode when a mult/div or HI/LO access cannot proceed.

Parameters:
- DATA_WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- reg_s_data_ex  in  32  rs operand (operand A).
- reg_t_data_ex  in  32  rt operand.
- imm_data_ex  in  32  sign- or zero-extended immediate, prepared by decode.
- alu_src_sel_ex  in  1  operand B select: 0 = reg_t_data_ex, 1 = imm_data_ex.
- alu_op_ex  in  4  ALU operation code (see Behaviour).
- md_op_ex  in  3  mul/div operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 reserved (treated as NONE).
- reg_d_we_ex  in  1  register write enable, passed down the pipe.
- reg_d_addr_ex  in  5  destination register.
- reg_d_data_sel_ex  in  1  writeback source select, passed down the pipe.
- mem_we_ex  in  4  byte write enables, passed down the pipe.
- stall_ex  out  1  combinational; decode must hold its EX inputs stable while this is high.
- alu_data_mem  out  32  registered result (ALU result or HI/LO) / memory address.
- reg_t_data_mem  out  32  registered rt data (store data).
- reg_d_we_mem  out  1  registered.
- reg_d_addr_mem  out  5  registered.
- reg_d_data_sel_mem  out  1  registered.
- mem_we_mem  out  4  registered.

Behaviour:
- Reset: a synchronous rst clears every registered output to 0, and clears HI, LO, the busy flag and the iteration counter to 0. An rst during a mul/div aborts it; HI/LO read 0 afterwards.

ALU:
- B = alu_src_sel_ex ? imm : rt.
- Operations: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 1/0), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (B<<16), 12-15 result 0.
- Shifts: B is shifted by A[4:0].
- ADD/SUB wrap modulo 2^32 with no overflow detection.

Latency:
- Non-stalled instruction: all EX inputs appear on the `*_mem` outputs one clock later.

Mul/div unit (busy flag, 6-bit counter):
- An op 1-4 with busy=0 is accepted on that edge. Operands are latched and the counter is loaded with 32.
- busy stays high for exactly 32 cycles; one radix-2 iteration runs per cycle.
- HI/LO are written on the edge that ends the 32nd busy cycle, and busy falls on the same edge.
- MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
- DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend, with no exception.
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- MFHI/MFLO with busy=0: alu_data_mem = HI/LO on the next edge. The instruction's own reg_d_we/addr pass through.

Stall:
- stall_ex = busy && (md_op_ex is 1-6).
- While stalled, the next edge injects a bubble: reg_d_we_mem = 0, mem_we_mem = 0, other outputs don't-care (driven 0). The EX inputs are not consumed.
- A non-mul/div instruction issued while busy proceeds normally, and the mul/div unit continues in the background.
- A stalled MFHI/MFLO completes on the first edge with busy=0. That edge is the edge after HI/LO are written, so the new values are returned.
- A new mul/div op held while busy is accepted on the first edge with busy=0.
- A mul/div op is accepted only when not stalled. Exactly one acceptance occurs per instruction.

Optional Feature:
- Macro: EXECUTE_MULDIV_EN.
- Defined: the mul/div unit, HI/LO and stall are present, as described above.
- Undefined: no mul/div hardware. stall_ex is tied to 0. md_op_ex 1-4 behave as instructions with no effect beyond their passed-through control. MFHI/MFLO return 0 on alu_data_mem.

Test Plan:
- After rst, ADD with A=0x7FFFFFFF, B=1 -> alu_data_mem = 0x80000000 one cycle later. SLT with A=-1, B=1 -> 1. SLTU with the same operands -> 0. SRA with B=0x80000000, shamt 4 -> 0xF8000000.
- MULT 0xFFFFFFFE x 3, then MFLO, MFHI back to back -> stall_ex high; first MFLO completes 0xFFFFFFFA, then MFHI completes 0xFFFFFFFF. A bubble (reg_d_we_mem = 0) appears on every stalled cycle.
- DIV -7 / 2, then MFLO/MFHI -> 0xFFFFFFFD and 0xFFFFFFFF. DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, followed by three ADDs -> the ADDs flow with no stall, and HI/LO later read 0xFFFFFFFE / 0x00000001.
- Assert rst on busy cycle 10 of a DIVU -> busy = 0 and all outputs 0 on the next cycle. A subsequent MFHI returns 0 with no stall.
- Build without EXECUTE_MULDIV_EN: MULT followed by MFLO -> stall_ex never high, and MFLO returns 0.
